ifmap_spad_ctrl: RTL and testbench

Sequencing controller for one PE's input-feature-map scratchpad. It generates write enables and addresses to fill the scratchpad from the ifmap buffer stream. It generates read addresses that walk sliding convolution windows (length K, stride S) for the MAC. It manages the scratchpad as a circular buffer, so new rows arrive while earlier windows are being consumed.

---
 rtl/ifmap_spad_ctrl.sv | 144 ++++++++++++++
 tb/tb_ifmap_spad_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_spad_ctrl.sv
// Input-feature-map scratchpad sequencer: fills a circular scratchpad from the
// ifmap stream and walks sliding windows (length K, stride S) out to the MAC.
module ifmap_spad_ctrl #(
   parameter int IFMAP_SPAD_ROW = 12,
   parameter int ADDR_W         = 4,
   parameter int CNT_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] filt_len,
   input  logic [ADDR_W-1:0] stride,
   input  logic [CNT_W-1:0]  n_windows,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              spad_wen,
   output logic [ADDR_W-1:0] spad_waddr,
   output logic [ADDR_W-1:0] spad_raddr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef logic [ADDR_W-1:0] addr_t;
   // One bit wider than an address: holds occupancy 0..ROW and pointer sums.
   typedef logic [ADDR_W:0]   cnt_t;
   typedef logic [CNT_W-1:0]  win_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam cnt_t  ROW_C  = cnt_t'(IFMAP_SPAD_ROW);
   localparam addr_t LAST_A = addr_t'(IFMAP_SPAD_ROW - 1);

   state_t state_q, state_d;
   addr_t  k_q, k_d, s_q, s_d;
   addr_t  wptr_q, wptr_d, base_q, base_d, offset_q, offset_d;
   cnt_t   count_q, count_d;
   win_t   win_cnt_q, win_cnt_d, n_q, n_d;

   addr_t  k_clamp, s_clamp;
   cnt_t   rsum, bsum;
   logic   run, wr, rd;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      k_clamp = filt_len;
      if (filt_len == '0)
         k_clamp = addr_t'(1);
      else if ({1'b0, filt_len} > ROW_C)
         k_clamp = addr_t'(IFMAP_SPAD_ROW);
      s_clamp = stride;
      if (stride == '0)
         s_clamp = addr_t'(1);
      else if (stride > k_clamp)
         s_clamp = k_clamp;

      run        = (state_q == RUN);
      in_ready   = run && (count_q < ROW_C);
      out_valid  = run && (count_q >= {1'b0, k_q});
      out_last   = out_valid && (offset_q == k_q - addr_t'(1));
      spad_wen   = in_valid && in_ready;
      wr         = spad_wen;
      rd         = out_valid && out_ready;
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
      spad_waddr = wptr_q;

      rsum       = {1'b0, base_q} + {1'b0, offset_q};
      spad_raddr = (rsum >= ROW_C) ? addr_t'(rsum - ROW_C) : addr_t'(rsum);
      bsum       = {1'b0, base_q} + {1'b0, s_q};

      state_d   = state_q;
      k_d       = k_q;
      s_d       = s_q;
      n_d       = n_q;
      wptr_d    = wptr_q;
      base_d    = base_q;
      offset_d  = offset_q;
      count_d   = count_q;
      win_cnt_d = win_cnt_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               k_d       = k_clamp;
               s_d       = s_clamp;
               n_d       = n_windows;
               wptr_d    = '0;
               base_d    = '0;
               offset_d  = '0;
               count_d   = '0;
               win_cnt_d = '0;
               state_d   = (n_windows == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (wr)
               wptr_d = (wptr_q == LAST_A) ? '0 : wptr_q + addr_t'(1);
            if (rd) begin
               if (out_last) begin
                  offset_d  = '0;
                  base_d    = (bsum >= ROW_C) ? addr_t'(bsum - ROW_C) : addr_t'(bsum);
                  win_cnt_d = win_cnt_q + win_t'(1);
                  if (win_cnt_d == n_q)
                     state_d = DONE;
               end else begin
                  offset_d = offset_q + addr_t'(1);
               end
            end
            // Occupancy only shrinks on a window boundary, so the live window is never overwritten.
            count_d = count_q + cnt_t'(wr) - ((rd && out_last) ? {1'b0, s_q} : '0);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= '0;
         s_q       <= '0;
         n_q       <= '0;
         wptr_q    <= '0;
         base_q    <= '0;
         offset_q  <= '0;
         count_q   <= '0;
         win_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         s_q       <= s_d;
         n_q       <= n_d;
         wptr_q    <= wptr_d;
         base_q    <= base_d;
         offset_q  <= offset_d;
         count_q   <= count_d;
         win_cnt_q <= win_cnt_d;
      end
   end

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Self-checking bench for ifmap_spad_ctrl: directed scenarios with randomized
// handshakes, checked against an occupancy/window-index model of the scratchpad.
module tb_ifmap_spad_ctrl;

   localparam int ROW = 12;
   localparam int AW  = 4;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] filt_len, stride;
   logic [CW-1:0] n_windows;
   logic          in_valid, in_ready, spad_wen;
   logic [AW-1:0] spad_waddr, spad_raddr;
   logic          out_valid, out_ready, out_last, busy, done;

   ifmap_spad_ctrl #(.IFMAP_SPAD_ROW(ROW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .filt_len(filt_len), .stride(stride),
      .n_windows(n_windows), .in_valid(in_valid), .in_ready(in_ready),
      .spad_wen(spad_wen), .spad_waddr(spad_waddr), .spad_raddr(spad_raddr),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int rd_log[$];     // observed read addresses of accepted reads
   int base_log[$];   // observed address of each window's first element
   int obs_wr;
   int wr_at_hold;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_b({tag, "_in_ready"}, in_ready, 1'b0);
      check_b({tag, "_wen"},      spad_wen, 1'b0);
      check_b({tag, "_out_valid"}, out_valid, 1'b0);
      check_b({tag, "_out_last"}, out_last, 1'b0);
      check_b({tag, "_busy"},     busy, 1'b0);
      check_b({tag, "_done"},     done, 1'b0);
      check({tag, "_waddr"}, 32'(spad_waddr), 32'd0);
      check({tag, "_raddr"}, 32'(spad_raddr), 32'd0);
   endtask

   // One pass. The model tracks total writes, completed windows and the element
   // index inside the current window; occupancy is writes - windows*S.
   task automatic run_pass(input int fl, input int st, input int nw, input int feed_max,
                           input int vprob, input int rprob, input int hold,
                           input int restart_at, input int abort_win);
      int k, s, w_tot, wins, j, cyc, occ;
      bit fin, exp_ir, exp_ov;
      k = (fl == 0) ? 1 : (fl > ROW ? ROW : fl);
      s = (st == 0) ? 1 : (st > k ? k : st);
      w_tot = 0; wins = 0; j = 0; cyc = 0; fin = 0;
      obs_wr = 0; wr_at_hold = -1;
      rd_log.delete();
      base_log.delete();

      @(negedge clk);
      start = 1'b1; filt_len = AW'(fl); stride = AW'(st); n_windows = CW'(nw);
      in_valid = 1'b0; out_ready = 1'b0;

      while (!fin && cyc < 2000) begin
         @(negedge clk);
         start = (cyc == restart_at);
         if (start) begin
            filt_len  = AW'($urandom);
            stride    = AW'($urandom);
            n_windows = CW'($urandom_range(1, 255));
         end
         in_valid  = (w_tot < feed_max) && ($urandom_range(0, 99) < vprob);
         out_ready = (cyc >= hold) && ($urandom_range(0, 99) < rprob);
         #1;
         if (cyc == hold) wr_at_hold = obs_wr;
         occ    = w_tot - wins * s;
         exp_ir = (occ < ROW);
         exp_ov = (occ >= k);
         check_b("run_busy", busy, 1'b1);
         check_b("run_done", done, 1'b0);
         check_b("in_ready", in_ready, exp_ir);
         check_b("spad_wen", spad_wen, exp_ir && in_valid);
         if (exp_ir) check("spad_waddr", 32'(spad_waddr), 32'(w_tot % ROW));
         check_b("out_valid", out_valid, exp_ov);
         if (exp_ov) begin
            check("spad_raddr", 32'(spad_raddr), 32'((wins * s + j) % ROW));
            check_b("out_last", out_last, j == k - 1);
         end
         if (spad_wen) obs_wr++;

         if (abort_win >= 0 && wins == abort_win && j == 1) begin
            rst = 1'b1;
            #1;
            check_idle_outputs("abort");
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk); #1;
               check_b("abort_no_done", done, 1'b0);
               check_b("abort_no_busy", busy, 1'b0);
            end
            return;
         end

         if (exp_ir && in_valid) w_tot++;
         if (exp_ov && out_ready) begin
            rd_log.push_back(int'(spad_raddr));
            if (j == 0) base_log.push_back(int'(spad_raddr));
            if (j == k - 1) begin
               j = 0;
               wins++;
               if (wins == nw) fin = 1;
            end else begin
               j++;
            end
         end
         cyc++;
      end

      check_b("pass_complete", fin, 1'b1);
      start = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check_b("end_done", done, 1'b1);
      check_b("end_busy", busy, 1'b1);
      check_b("end_in_ready", in_ready, 1'b0);
      check_b("end_out_valid", out_valid, 1'b0);
      @(negedge clk); #1;
      check_b("post_done", done, 1'b0);
      check_b("post_busy", busy, 1'b0);
   endtask

   task automatic check_bases(input string tag, input int s_exp, input int n_exp);
      check({tag, "_nwin"}, 32'(base_log.size()), 32'(n_exp));
      foreach (base_log[i])
         check({tag, "_base"}, 32'(base_log[i]), 32'((i * s_exp) % ROW));
   endtask

   initial begin
      int s1_exp[12];
      s1_exp = '{0, 1, 2, 1, 2, 3, 2, 3, 4, 3, 4, 5};
      rst = 1'b1; start = 1'b0; filt_len = '0; stride = '0; n_windows = '0;
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      check_idle_outputs("reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Basic window sweep
      run_pass(3, 1, 4, 6, 100, 100, 0, -1, -1);
      check("s1_nreads", 32'(rd_log.size()), 32'd12);
      foreach (rd_log[i])
         if (i < 12) check("s1_raddr_seq", 32'(rd_log[i]), 32'(s1_exp[i]));
      check("s1_writes", 32'(obs_wr), 32'd6);

      // Full stall, then release
      run_pass(3, 1, 4, 1000, 100, 100, 25, -1, -1);
      check("stall_writes", 32'(wr_at_hold), 32'd12);

      // Wrap-around with random handshakes
      run_pass(5, 2, 6, 15, 70, 60, 0, -1, -1);
      check_bases("wrap", 2, 6);
      check("wrap_last_win0", 32'(rd_log[25]), 32'd10);
      check("wrap_last_win4", 32'(rd_log[29]), 32'd2);

      // Clamping
      run_pass(3, 0, 5, 1000, 80, 70, 0, -1, -1);
      check_bases("clamp_s0", 1, 5);
      run_pass(0, 0, 7, 1000, 80, 70, 0, -1, -1);
      check_bases("clamp_k0", 1, 7);
      run_pass(3, 7, 6, 1000, 80, 70, 0, -1, -1);
      check_bases("clamp_s7", 3, 6);
      run_pass(15, 5, 3, 1000, 90, 80, 0, -1, -1);
      check_bases("clamp_k15", 5, 3);

      // Zero windows
      @(negedge clk);
      start = 1'b1; filt_len = AW'(3); stride = AW'(1); n_windows = '0; in_valid = 1'b1;
      #1;
      check_b("zero_busy_t", busy, 1'b0);
      @(negedge clk);
      start = 1'b0;
      #1;
      check_b("zero_done", done, 1'b1);
      check_b("zero_wen", spad_wen, 1'b0);
      check_b("zero_in_ready", in_ready, 1'b0);
      @(negedge clk); #1;
      check_b("zero_done_clr", done, 1'b0);
      check_b("zero_busy_clr", busy, 1'b0);
      check_b("zero_wen2", spad_wen, 1'b0);
      in_valid = 1'b0;

      // Start pulsed during RUN is ignored
      run_pass(4, 2, 5, 1000, 75, 65, 0, 6, -1);

      // Reset during the second window, then rerun the basic sweep
      run_pass(3, 1, 4, 1000, 100, 100, 0, -1, 1);
      run_pass(3, 1, 4, 6, 100, 100, 0, -1, -1);
      check("rerun_nreads", 32'(rd_log.size()), 32'd12);
      foreach (rd_log[i])
         if (i < 12) check("rerun_raddr_seq", 32'(rd_log[i]), 32'(s1_exp[i]));

      // Random configurations
      for (int r = 0; r < 4; r++)
         run_pass($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 20),
                  1000, 70, 60, 0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
